// File: rtl/typedefs_pkg.sv
// Shared type definitions for the Genius game blocks.
// Player states use a P_ prefix so they can coexist with other FSM enums here.
package typedefs_pkg;

    typedef enum logic [2:0] {
        P_IDLE,
        P_FETCH,
        P_WAIT_DATA,
        P_SHOW,
        P_GAP,
        P_FINISH
    } player_state_t;

endpackage

// File: rtl/sequence_player_if.sv
// Control, memory read and LED signals of the sequence player.
// master = game controller / memory side, slave = the player.
interface sequence_player_if #(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 5
);
    logic                  start;
    logic                  abort;
    logic [ADDR_WIDTH-1:0] length;
    logic                  speed;
    logic [DATA_WIDTH-1:0] mem_data;
    logic                  mem_rd;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] leds;
    logic                  busy;
    logic                  done;

    modport master (
        output start, abort, length, speed, mem_data,
        input  mem_rd, mem_addr, leds, busy, done
    );

    modport slave (
        input  start, abort, length, speed, mem_data,
        output mem_rd, mem_addr, leds, busy, done
    );
endinterface

// File: rtl/sequence_player_timer.sv
// Loadable down-counter; expire flags the last cycle of a loaded interval.
// The count parks at 0 once it has run out.
module cycle_timer #(
    parameter int CNT_WIDTH = 26
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [CNT_WIDTH-1:0] load_val,
    output logic                 expire
);
    logic [CNT_WIDTH-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else if (load)
            cnt_q <= load_val;
        else if (cnt_q != '0)
            cnt_q <= cnt_q - 1'b1;
    end

    assign expire = (cnt_q == CNT_WIDTH'(1)) && !load;
endmodule

// File: rtl/sequence_player.sv
// Timed playback of sequence items 0..length-1 onto the LEDs, one slot each:
// fetch, wait for data, on-time, gap; then a one-cycle done pulse.
module sequence_player
    import typedefs_pkg::*;
#(
    parameter int DATA_WIDTH     = 4,
    parameter int ADDR_WIDTH     = 5,
    parameter int CNT_WIDTH      = 26,
    parameter int ON_CYCLES_SLOW = 25_000_000,
    parameter int ON_CYCLES_FAST = 12_500_000,
    parameter int GAP_CYCLES     = 5_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    sequence_player_if.slave bus
);
    localparam logic [CNT_WIDTH-1:0] ON_SLOW = CNT_WIDTH'(ON_CYCLES_SLOW);
    localparam logic [CNT_WIDTH-1:0] ON_FAST = CNT_WIDTH'(ON_CYCLES_FAST);
    localparam logic [CNT_WIDTH-1:0] GAP_VAL = CNT_WIDTH'(GAP_CYCLES);
    localparam bit                   HAS_GAP = (GAP_CYCLES != 0);

    player_state_t         state_q;
    logic [ADDR_WIDTH-1:0] idx_q, len_q;
    logic                  spd_q;
    logic [DATA_WIDTH-1:0] item_q;

    logic                  on_load, on_expire, gap_load, gap_expire;
    logic [ADDR_WIDTH-1:0] idx_inc;

    // Separate on/gap timers: the gap load is triggered by the on-timer's
    // expire, which would otherwise feed back into its own load input.
    assign on_load  = (state_q == P_WAIT_DATA);
    assign gap_load = HAS_GAP && (state_q == P_SHOW) && on_expire;
    assign idx_inc  = idx_q + 1'b1;

    cycle_timer #(.CNT_WIDTH(CNT_WIDTH)) u_on_tmr (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (on_load),
        .load_val(spd_q ? ON_FAST : ON_SLOW),
        .expire  (on_expire)
    );

    cycle_timer #(.CNT_WIDTH(CNT_WIDTH)) u_gap_tmr (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (gap_load),
        .load_val(GAP_VAL),
        .expire  (gap_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= P_IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            spd_q   <= 1'b0;
            item_q  <= '0;
        end else if (state_q != P_IDLE && bus.abort) begin
            state_q <= P_IDLE;
        end else begin
            case (state_q)
                P_IDLE: if (bus.start && !bus.abort) begin
                    len_q   <= bus.length;
                    spd_q   <= bus.speed;
                    idx_q   <= '0;
                    state_q <= (bus.length == '0) ? P_FINISH : P_FETCH;
                end
                P_FETCH:     state_q <= P_WAIT_DATA;
                P_WAIT_DATA: begin
                    item_q  <= bus.mem_data;
                    state_q <= P_SHOW;
                end
                P_SHOW: if (on_expire) begin
                    if (HAS_GAP) begin
                        state_q <= P_GAP;
                    end else begin
                        idx_q   <= idx_inc;
                        state_q <= (idx_inc == len_q) ? P_FINISH : P_FETCH;
                    end
                end
                P_GAP: if (gap_expire) begin
                    idx_q   <= idx_inc;
                    state_q <= (idx_inc == len_q) ? P_FINISH : P_FETCH;
                end
                P_FINISH: state_q <= P_IDLE;
                default:  state_q <= P_IDLE;
            endcase
        end
    end

    assign bus.busy     = (state_q != P_IDLE);
    assign bus.done     = (state_q == P_FINISH);
    assign bus.mem_rd   = (state_q == P_FETCH);
    assign bus.mem_addr = idx_q;
    assign bus.leds     = (state_q == P_SHOW) ? item_q : '0;
endmodule

// File: tb/tb_sequence_player.sv
// Directed + randomized playback checks of sequence_player against a
// slot-arithmetic reference model.
module tb_sequence_player;
    localparam int DW = 4, AW = 5, ON_S = 8, ON_F = 4, GAP = 2;

    typedef struct packed {
        logic          busy;
        logic          done;
        logic          rd;
        logic [AW-1:0] addr;
        logic [DW-1:0] leds;
    } exp_t;

    logic clk = 1'b0, rst_n = 1'b0;
    int   n_assert = 0, n_fail = 0;
    logic [DW-1:0] mem [32];

    always #5 clk = ~clk;

    sequence_player_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    sequence_player #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(8),
        .ON_CYCLES_SLOW(ON_S), .ON_CYCLES_FAST(ON_F), .GAP_CYCLES(GAP)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Synchronous-read memory, one cycle latency.
    always @(posedge clk) if (bus.mem_rd) bus.mem_data <= mem[bus.mem_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Cycle c counts from 1 after the edge that sampled start.
    function automatic exp_t model(input int c, input int n, input int on);
        exp_t e;
        int slot, total, k, off;
        e = '0;
        slot = 2 + on + GAP;
        total = n * slot;
        if (c <= total) begin
            k = (c - 1) / slot;
            off = (c - 1) % slot;
            e.busy = 1'b1;
            e.rd = (off == 0);
            e.addr = AW'(k);
            if (off >= 2 && off < 2 + on) e.leds = mem[k];
        end else begin
            e.addr = AW'(n);
            if (c == total + 1) begin
                e.busy = 1'b1;
                e.done = 1'b1;
            end
        end
        return e;
    endfunction

    task automatic check_out(input string tag, input exp_t e, input bit with_addr);
        chk({tag, ".busy"}, bus.busy, e.busy);
        chk({tag, ".done"}, bus.done, e.done);
        chk({tag, ".rd"},   bus.mem_rd, e.rd);
        chk({tag, ".leds"}, bus.leds, e.leds);
        if (with_addr) chk({tag, ".addr"}, bus.mem_addr, e.addr);
    endtask

    // Called at a negedge; returns at the negedge of the idle cycle after done.
    task automatic play(input string name, input int n, input bit spd,
                        input int abort_at, input int reset_at, input bit noise);
        int on, total, last;
        on = spd ? ON_F : ON_S;
        total = n * (2 + on + GAP);
        last = (abort_at > 0) ? abort_at + 3 : total + 2;
        bus.start = 1'b1; bus.length = AW'(n); bus.speed = spd;
        @(negedge clk);
        bus.start = 1'b0;
        for (int c = 1; c <= last; c++) begin
            if (abort_at > 0 && c > abort_at)
                check_out($sformatf("%s.c%0d", name, c), '0, 1'b0);
            else
                check_out($sformatf("%s.c%0d", name, c), model(c, n, on), 1'b1);
            if (c == reset_at) begin
                #2 rst_n = 1'b0;
                #1 check_out($sformatf("%s.rst", name), '0, 1'b1);
                @(negedge clk) rst_n = 1'b1;
                @(negedge clk) check_out($sformatf("%s.rel", name), '0, 1'b1);
                return;
            end
            bus.abort = (c == abort_at);
            if (noise && c < total) begin
                bus.speed = ~bus.speed;
                bus.length = AW'($urandom);
                bus.start = (c == 5);
            end else begin
                bus.start = 1'b0;
            end
            if (c < last) @(negedge clk);
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.abort = 1'b0; bus.length = '0; bus.speed = 1'b0;
        foreach (mem[i]) mem[i] = '0;
        mem[0] = 4'b0001; mem[1] = 4'b0010; mem[2] = 4'b0100;
        #1 check_out("reset", '0, 1'b1);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk) check_out("post_reset", '0, 1'b1);

        play("fast3", 3, 1'b1, 0, 0, 1'b0);
        play("slow2_noise", 2, 1'b0, 0, 0, 1'b1);
        play("zero", 0, 1'b1, 0, 0, 1'b0);
        play("abort", 3, 1'b1, 5, 0, 1'b0);
        play("replay", 3, 1'b1, 0, 0, 1'b0);

        // start and abort together in IDLE: request dropped
        bus.start = 1'b1; bus.abort = 1'b1; bus.length = AW'(3);
        @(negedge clk);
        bus.start = 1'b0; bus.abort = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            check_out($sformatf("start_abort.c%0d", c), '0, 1'b0);
            @(negedge clk);
        end

        play("b2b_a", 1, 1'b1, 0, 0, 1'b0);
        play("b2b_b", 2, 1'b1, 0, 0, 1'b0);
        play("reset_mid", 3, 1'b1, 0, 7, 1'b0);
        play("after_rst", 2, 1'b0, 0, 0, 1'b0);

        for (int r = 0; r < 6; r++) begin
            for (int a = 0; a < 8; a++) mem[a] = DW'(1) << $urandom_range(0, DW - 1);
            play($sformatf("rand%0d", r), int'($urandom_range(0, 6)),
                 1'($urandom_range(0, 1)), 0, 0, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/sequence_player.md
# sequence_player

Timed playback engine for the Genius game. When the game controller requests a show, this block reads sequence items `0..length-1` from the sequence memory, one per slot. It drives each item onto the player LEDs for a speed-dependent on-time, followed by a blank gap. It pulses `done` when playback completes. It sits between the game controller and the sequence memory, and owns the memory read port while `busy`.

## Interface
- `DATA_WIDTH`, default 4: LED/item width (one-hot colour).
- `ADDR_WIDTH`, default 5: sequence memory address width.
- `CNT_WIDTH`, default 26: slot timer width.
- `ON_CYCLES_SLOW`, default 25_000_000: LED on-time when `speed`=0. Must be ≥1 and < 2^CNT_WIDTH.
- `ON_CYCLES_FAST`, default 12_500_000: LED on-time when `speed`=1. Must be ≥1.
- `GAP_CYCLES`, default 5_000_000: blank time after each item. 0 means no gap.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  single-cycle request to play; honoured only in IDLE.
- `abort`  in  1  cancel playback; has priority over everything except reset.
- `length`  in  ADDR_WIDTH  number of items to play; sampled with `start`.
- `speed`  in  1  speed select; sampled with `start`.
- `mem_data`  in  DATA_WIDTH  memory read data, valid 1 cycle after `mem_rd`.
- `mem_rd`  out  1  memory read strobe.
- `mem_addr`  out  ADDR_WIDTH  read address.
- `leds`  out  DATA_WIDTH  LED drive.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, FETCH, WAIT_DATA, SHOW, GAP, FINISH.
- **IDLE:**
  - On `start`, latch `length` into `len_q` and `speed` into `spd_q`, and clear `idx`.
  - If `length`=0, go to FINISH; otherwise go to FETCH.
- **FETCH:** assert `mem_rd` with `mem_addr`=`idx`, then go to WAIT_DATA.
- **WAIT_DATA:**
  - Capture `mem_data` into `item_q`.
  - Load the timer with the on-time: `ON_CYCLES_FAST` if `spd_q`, else `ON_CYCLES_SLOW`.
  - Go to SHOW.
- **SHOW:**
  - `leds`=`item_q`.
  - The timer counts down. When it reaches 1, go to GAP and load `GAP_CYCLES`. If `GAP_CYCLES`=0, skip GAP and take the end-of-slot decision directly.
- **GAP:**
  - `leds`=0.
  - When the timer reaches 1, take the end-of-slot decision.
- **End-of-slot decision:** `idx`+1. If the new `idx` equals `len_q`, go to FINISH; otherwise go to FETCH.
- **FINISH:** `done`=1 for one cycle, then go to IDLE.
- `start` is ignored while `busy`.
- `abort` in any non-IDLE state:
  - The next state is IDLE and `leds` go to 0.
  - No `done` is produced.
  - An `abort` in the same cycle as `start` in IDLE wins, so the request is dropped.
- `mem_addr` holds `idx` in all states; `mem_rd` is high only in FETCH.
- `idx` is ADDR_WIDTH bits. `length`=2^ADDR_WIDTH is unrepresentable; the maximum number of items played is 2^ADDR_WIDTH−1.

## Timing
- All outputs are registered or decoded directly from the state register.
- Reset values: state IDLE; `busy`=0, `done`=0, `mem_rd`=0, `mem_addr`=0, `leds`=0; internal `idx`=0, `item_q`=0, timer=0.
- Reset asserted mid-playback returns to IDLE immediately. LEDs go off and no `done` is produced.
- `start` sampled at edge 0 gives FETCH in cycle 1.
- Per-item slot length is 2 + ON + GAP cycles, where ON is the on-time selected by `spd_q` (`ON_CYCLES_FAST` or `ON_CYCLES_SLOW`) and GAP is `GAP_CYCLES`.
- For N≥1 items, `done` is high in cycle N·(2+ON+GAP)+1 and `busy` drops the cycle after. For N=0, `done` is in cycle 1.
- The memory read latency is fixed at 1 cycle. No back-pressure exists.
- `speed` and `length` changes during playback have no effect.

## Structure
- Add `player_state_t` (the 6 states above) to `typedefs_pkg`, alongside the controller's `state_t`.
- Sub-module `cycle_timer` (CNT_WIDTH down-counter):
  - inputs `load` and `load_val`;
  - output `expire`, high when count==1 and not loading.
- The FSM, `idx`/`len_q`/`spd_q`/`item_q` registers and output decode stay in `sequence_player`.

## Test plan
Bench parameters: `ON_CYCLES_SLOW`=8, `ON_CYCLES_FAST`=4, `GAP_CYCLES`=2. The memory model returns 4'b0001, 4'b0010, 4'b0100 at addresses 0, 1, 2.
- **Fast playback:** `start`, `length`=3, `speed`=1.
  - `mem_rd` pulses at cycles 1, 9, 17 with addresses 0, 1, 2.
  - `leds` is 0001 for cycles 3–6, 0010 for cycles 11–14, 0100 for cycles 19–22, and 0 otherwise.
  - `done` is high only in cycle 25.
- **Slow playback:** `length`=2, `speed`=0. Each slot is 12 cycles and `done` is in cycle 25. Toggling `speed` mid-play changes nothing.
- **Zero length:** `length`=0. `done` is in cycle 1, `mem_rd` never asserts, `leds` stays 0.
- **Abort:** `abort` in cycle 5, during SHOW of item 0. The block is in IDLE in cycle 6 with `leds`=0 and `busy`=0, and `done` never fires. A new `start` then replays from address 0.
- **Busy and simultaneous requests:**
  - A second `start` during playback is ignored.
  - `start`+`abort` in the same IDLE cycle keeps the block in IDLE.
  - `start` in the cycle after `done` begins a new playback.
- **Reset mid-play:** `rst_n` low asynchronously during GAP. All outputs are 0 immediately, and the block is in IDLE after release.
